mult_operand_sequencer: RTL and testbench
=========================================

// Module: mult_operand_sequencer
// PURPOSE
//  Sits directly upstream of the sequential Booth multiplier and also collects its result.
//  - Buffers signed operand pairs in a small FIFO and launches one multiplication at a time.
//  - Waits for the multiplier's done level, captures the product and add/sub counts.
//  - Presents the result on a valid/ready output port.
// PARAMETERS
//  W        32  operand width; product is 2*W
//  DEPTH     4  operand FIFO entries, power of 2, >=2
//  GUARD     2  cycles after mul_start before mul_done is sampled
//  TMO_MAX  40  timeout limit in cycles (used only with MULSEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous, active-low reset
//  in_valid     in   1      operand pair offered
//  in_ready     out  1      FIFO not full
//  in_a, in_b   in   W      signed multiplicand / multiplier
//  mul_start    out  1      one-cycle launch pulse to multiplier
//  mul_a, mul_b out  W      operands held stable from launch until capture
//  mul_done     in   1      multiplier done level
//  mul_product  in   2*W    signed product from multiplier
//  mul_adds     in   7      multiplier add count
//  mul_subs     in   7      multiplier subtract count
//  out_valid    out  1      result held
//  out_ready    in   1      consumer accepts result
//  out_product  out  2*W    captured product
//  out_adds     out  7      captured add count
//  out_subs     out  7      captured subtract count
//  busy         out  1      FSM not in IDLE, or FIFO not empty
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, FIFO empty; in_ready rises on the first clock after release.
//  Input: push when in_valid && in_ready; in_ready = !full.
//   - Full: input is stalled, no data lost.
//   - Pointers are log2(DEPTH)+1 bits; wrap-around is modulo.
//  FSM:
//   - IDLE -> LAUNCH when the FIFO is non-empty and out_valid==0.
//   - LAUNCH: pop head into mul_a/mul_b and pulse mul_start=1 for exactly 1 cycle. -> GUARDW
//   - GUARDW: count GUARD cycles and ignore mul_done. -> WAIT
//   - WAIT: on mul_done==1, capture mul_product/adds/subs into out_* and set out_valid. -> HOLD
//   - HOLD: on out_valid && out_ready, clear out_valid. -> IDLE
//  Latency: a push into an empty FIFO reaches mul_start 2 cycles later.
//  Output: out_* stay stable while out_valid && !out_ready.
//  Simultaneous push and pop in LAUNCH: both take effect; count unchanged.
//  Push while FIFO empty: the entry is visible to IDLE the next cycle (no bypass).
//  mul_a/mul_b hold their value until the next LAUNCH.
//  Reset mid-operation: FIFO and result are discarded, mul_start is forced 0, FSM=IDLE.
//  Counts are passed through unmodified; there is no arithmetic on the product.
// CONFIGURATION
//  MULSEQ_TIMEOUT_EN defined:
//   - Adds output err (1 bit, reset 0) and a 6-bit cycle counter running in GUARDW+WAIT.
//   - If the counter reaches TMO_MAX without mul_done:
//     - out_product=0, out_adds=0, out_subs=0, out_valid=1, err=1; -> HOLD.
//   - err clears on the output handshake.
//  Undefined: no err port, no counter; WAIT waits indefinitely.
// STRUCTURE
//  Shared package mult_pkg:
//   - seq_state_t enum {IDLE, LAUNCH, GUARDW, WAIT, HOLD}
//   - localparams CNT_W=7 and PROD_W=2*W
//  Sub-module: mult_op_fifo (sync FIFO, DEPTH x 2W; ports push/pop/full/empty/head).
// TESTING
//  1. Reset, push (A=7, B=-3); model done after 33 cycles with product -21, adds=1, subs=2
//     -> mul_start once; out_valid with out_product=-21, out_adds=1, out_subs=2.
//  2. Push 5 pairs back-to-back with DEPTH=4, out_ready=1
//     -> in_ready low after the 4th push; all 5 products emerge in order.
//  3. Hold out_ready=0 with 2 pairs queued
//     -> out_* remain stable; no second mul_start until the handshake.
//  4. Leave mul_done high from the previous result, then push a new pair
//     -> the stale done is ignored for GUARD cycles; only the correct new product is captured.
//  5. Assert rst_n=0 while in WAIT with 2 pairs queued
//     -> out_valid=0, in_ready=1 after release, no further mul_start.
//  6. (MULSEQ_TIMEOUT_EN) Never assert mul_done
//     -> after 40 cycles: err=1, out_valid=1, out_product=0; err clears on the handshake.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the Booth multiplier operand sequencer.
package mult_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 2 * OP_W;
  localparam int CNT_W  = 7;
  localparam int TMO_W  = 6;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    GUARDW,
    WAIT,
    HOLD
  } seq_state_t;

endpackage

// File: rtl/mult_op_fifo.sv
// Synchronous operand FIFO with extra-MSB pointers; head is a registered-memory peek.
module mult_op_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/mult_operand_sequencer.sv
// Queues operand pairs, launches the Booth multiplier one job at a time and holds its result.
// Optional MULSEQ_TIMEOUT_EN adds an err output and a GUARDW+WAIT timeout counter.
module mult_operand_sequencer
  import mult_pkg::*;
#(
  parameter int W       = OP_W,
  parameter int DEPTH   = 4,
  parameter int GUARD   = 2,
  parameter int TMO_MAX = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             mul_start,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic             mul_done,
  input  logic [2*W-1:0]   mul_product,
  input  logic [CNT_W-1:0] mul_adds,
  input  logic [CNT_W-1:0] mul_subs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_product,
  output logic [CNT_W-1:0] out_adds,
  output logic [CNT_W-1:0] out_subs,
`ifdef MULSEQ_TIMEOUT_EN
  output logic             err,
`endif
  output logic             busy
);

  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GUARD < 1 || TMO_MAX < 1 || TMO_MAX > 63)
  begin : g_bad_param
    $error("mult_operand_sequencer: illegal DEPTH/GUARD/TMO_MAX");
  end

  seq_state_t      state, state_nx;
  logic [GW-1:0]   g_cnt;
  logic            ready_en;
  logic            push, pop, full, empty;
  logic [2*W-1:0]  head;
  logic            load, capture, hs;
  logic            timeout;

  mult_op_fifo #(.DW(2*W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({in_a, in_b}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // ready_en keeps in_ready low until the first clock after reset release.
  assign in_ready  = ready_en && !full;
  assign push      = in_valid && in_ready;
  assign pop       = (state == LAUNCH);
  assign mul_start = (state == LAUNCH);
  assign hs        = out_valid && out_ready;
  assign busy      = (state != IDLE) || !empty;

`ifdef MULSEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  assign timeout = (state == WAIT) && !mul_done && (tmo_cnt == TMO_W'(TMO_MAX - 1));
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    capture  = 1'b0;
    unique case (state)
      IDLE: if (!empty && !out_valid) begin
        load     = 1'b1;
        state_nx = LAUNCH;
      end
      LAUNCH: state_nx = GUARDW;
      GUARDW: if (g_cnt == GW'(GUARD - 1)) state_nx = WAIT;
      WAIT: begin
        if (mul_done) begin
          capture  = 1'b1;
          state_nx = HOLD;
        end else if (timeout) begin
          state_nx = HOLD;
        end
      end
      HOLD:    if (hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      g_cnt       <= '0;
      ready_en    <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_adds    <= '0;
      out_subs    <= '0;
    end else begin
      state    <= state_nx;
      ready_en <= 1'b1;
      g_cnt    <= (state == GUARDW) ? g_cnt + 1'b1 : '0;
      // Operands are loaded on entry to LAUNCH so they are valid alongside mul_start.
      if (load) {mul_a, mul_b} <= head;
      if (capture) begin
        out_valid   <= 1'b1;
        out_product <= mul_product;
        out_adds    <= mul_adds;
        out_subs    <= mul_subs;
      end else if (timeout) begin
        out_valid   <= 1'b1;
        out_product <= '0;
        out_adds    <= '0;
        out_subs    <= '0;
      end else if (hs) begin
        out_valid   <= 1'b0;
      end
    end
  end

`ifdef MULSEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (state == LAUNCH)                         tmo_cnt <= '0;
      else if (state == GUARDW || state == WAIT)   tmo_cnt <= tmo_cnt + 1'b1;
      if (timeout)  err <= 1'b1;
      else if (hs)  err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed bench with a behavioural Booth multiplier model and an in-order result scoreboard.
`timescale 1ns/1ps
module tb_mult_operand_sequencer;

  localparam int W = 32, DEPTH = 4, GUARD = 2, TMO_MAX = 40, LAT = 33;

  typedef struct packed {
    logic [63:0] p;
    logic [6:0]  adds;
    logic [6:0]  subs;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic        mul_start;
  logic [31:0] mul_a, mul_b;
  logic        mul_done;
  logic [63:0] mul_product;
  logic [6:0]  mul_adds, mul_subs;
  logic        out_valid, out_ready;
  logic [63:0] out_product;
  logic [6:0]  out_adds, out_subs;
  logic        busy;
`ifdef MULSEQ_TIMEOUT_EN
  logic        err;
`endif

  res_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   starts   = 0;
  bit   mdl_en     = 1'b1;
  bit   stale_mode = 1'b0;

  always #5 clk = ~clk;

  mult_operand_sequencer #(.W(W), .DEPTH(DEPTH), .GUARD(GUARD), .TMO_MAX(TMO_MAX)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .mul_adds    (mul_adds),
    .mul_subs    (mul_subs),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_adds    (out_adds),
    .out_subs    (out_subs),
`ifdef MULSEQ_TIMEOUT_EN
    .err         (err),
`endif
    .busy        (busy)
  );

  // Radix-2 Booth reference: product plus add/subtract counts over the multiplier bits.
  function automatic res_t booth(input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic prev;
    prev   = 1'b0;
    r.adds = '0;
    r.subs = '0;
    r.p    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    for (int i = 0; i < 32; i++) begin
      if (b[i] && !prev) r.subs = r.subs + 7'd1;
      if (!b[i] && prev) r.adds = r.adds + 7'd1;
      prev = b[i];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input res_t exp);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (in_ready !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("push_accept", 64'(in_ready), 64'd1);
    sb.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    push_exp(a, b, booth(a, b));
  endtask

  task automatic wait_out_valid(input string tag, input int budget);
    int t;
    t = 0;
    while (out_valid !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(tag, 64'(out_valid), 64'd1);
  endtask

  task automatic drain(input string tag, input int budget);
    int t;
    t = 0;
    while ((sb.size() != 0 || busy !== 1'b0 || out_valid !== 1'b0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  // Behavioural multiplier: done level after LAT cycles; in stale mode the old done lingers.
  initial begin : mul_model
    res_t r;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && mul_start === 1'b1) begin
        starts++;
        r = booth(mul_a, mul_b);
        if (!stale_mode) mul_done = 1'b0;
        if (mdl_en) begin
          for (int i = 0; i < LAT && rst_n === 1'b1; i++) begin
            @(negedge clk);
            if (i == GUARD) mul_done = 1'b0;
          end
          if (rst_n === 1'b1) begin
            mul_product = r.p;
            mul_adds    = r.adds;
            mul_subs    = r.subs;
            mul_done    = 1'b1;
          end else begin
            mul_done = 1'b0;
          end
        end else begin
          mul_done = 1'b0;
        end
      end
    end
  end

  // Compare each accepted result against the scoreboard just before the handshake edge.
  initial begin : monitor
    res_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        check("sb_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_product", out_product, e.p);
          check("sb_adds", 64'(out_adds), 64'(e.adds));
          check("sb_subs", 64'(out_subs), 64'(e.subs));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int s0;
    int t;
    logic [63:0] p0;
    bit stable;
    res_t zero_res;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    mul_done = 1'b0; mul_product = '0; mul_adds = '0; mul_subs = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_mul_start", 64'(mul_start), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_product", out_product, 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_release", 64'(in_ready), 64'd1);

    // 1: single job, latency to mul_start and captured result
    s0 = starts;
    push(32'd7, -32'sd3);
    check("t1_start_not_yet", 64'(mul_start), 64'd0);
    @(negedge clk);
    check("t1_start_latency", 64'(mul_start), 64'd1);
    check("t1_mul_a", 64'(mul_a), 64'd7);
    wait_out_valid("t1_out_valid", 80);
    check("t1_product", out_product, 64'(-21));
    check("t1_adds", 64'(out_adds), 64'd1);
    check("t1_subs", 64'(out_subs), 64'd2);
    check("t1_one_start", 64'(starts - s0), 64'd1);

    // 2: result held, fill the FIFO, then drain five jobs in order
    push(32'h8000_0000, 32'h7fff_ffff);
    push(-32'sd1, -32'sd1);
    push(32'd12345, 32'd0);
    push(32'h7fff_ffff, 32'h8000_0000);
    check("t2_full_in_ready", 64'(in_ready), 64'd0);
    check("t2_busy", 64'(busy), 64'd1);
    out_ready = 1'b1;
    push(32'hdead_beef, 32'h0000_5a5a);
    drain("t2_drain", 1000);
    check("t2_starts", 64'(starts - s0), 64'd6);

    // 3: back-pressure keeps the result stable and blocks the next launch
    out_ready = 1'b0;
    push(32'd1000, -32'sd77);
    push(-32'sd9, 32'd31);
    wait_out_valid("t3_out_valid", 80);
    p0 = out_product;
    s0 = starts;
    stable = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (out_product !== p0 || out_valid !== 1'b1) stable = 1'b0;
    end
    check("t3_stable", 64'(stable), 64'd1);
    check("t3_no_start", 64'(starts - s0), 64'd0);
    out_ready = 1'b1;
    drain("t3_drain", 300);
    check("t3_second_start", 64'(starts - s0), 64'd1);

    // 4: stale done from the previous job lingers through the guard window
    stale_mode = 1'b1;
    push(-32'sd12345, 32'd678);
    drain("t4_drain", 200);
    stale_mode = 1'b0;

    // 5: reset while waiting with two pairs queued
    push(32'd3, 32'd4);
    push(32'd5, 32'd6);
    push(32'd7, 32'd8);
    repeat (10) @(negedge clk);
    s0 = starts;
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("t5_rst_out_valid", 64'(out_valid), 64'd0);
    check("t5_rst_mul_start", 64'(mul_start), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    repeat (60) @(negedge clk);
    check("t5_no_start", 64'(starts - s0), 64'd0);
    check("t5_out_valid", 64'(out_valid), 64'd0);

`ifdef MULSEQ_TIMEOUT_EN
    // 6: multiplier never answers
    mdl_en    = 1'b0;
    out_ready = 1'b0;
    zero_res  = '0;
    push_exp(32'd11, 32'd13, zero_res);
    t = 0;
    while (mul_start !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (out_valid !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t6_tmo_window", 64'(t >= 40 && t <= 43), 64'd1);
    check("t6_err", 64'(err), 64'd1);
    check("t6_product", out_product, 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("t6_err_clear", 64'(err), 64'd0);
    check("t6_out_valid_clear", 64'(out_valid), 64'd0);
    mdl_en = 1'b1;
`else
    zero_res = '0;
    t = 0;
`endif

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
